// File: rtl/ysyx_22040365_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word at a time from instruction
// memory (one request outstanding at most) and presents it to decode on a valid/ready
// channel. Execute redirects override everything; a fetch already in flight when a
// redirect lands is flagged and its response discarded.
`timescale 1ns/1ps
module ysyx_22040365_ifu #(
  parameter int unsigned          ADDR_W   = 64,
  parameter logic [ADDR_W-1:0]    RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic              clk,
  input  logic              rst,

  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,

  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,

  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam logic [31:0] NopInst = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              drop_q, drop_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;

  logic [ADDR_W-1:0] target;

  // Redirect targets are forced onto a word boundary.
  assign target = redirect_pc & ~ADDR_W'(3);

  // Next-state logic; redirect takes priority in every state.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    case (state_q)
      StIdle: begin
        state_d = StReq;
        if (redirect_valid) pc_d = target;
      end
      StReq: begin
        if (imem_req_ready) state_d = StWait;
        if (redirect_valid) begin
          pc_d = target;
          // The old-address request was accepted this cycle; its response is stale.
          if (imem_req_ready) drop_d = 1'b1;
        end
      end
      StWait: begin
        if (redirect_valid) begin
          pc_d = target;
          if (imem_resp_valid) begin
            // Response arriving now is for the old PC: discard it and refetch.
            drop_d  = 1'b0;
            state_d = StReq;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = StReq;
          end else begin
            inst_d    = imem_resp_data;
            inst_pc_d = pc_q;
            state_d   = StHold;
          end
        end
      end
      StHold: begin
        if (redirect_valid) begin
          pc_d    = target;
          state_d = StReq;
        end else if (inst_ready) begin
          pc_d    = pc_q + ADDR_W'(4);
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      drop_q    <= 1'b0;
      inst_q    <= NopInst;
      inst_pc_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      drop_q    <= drop_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  // Outputs decoded from the state register or driven straight from flops.
  always_comb begin
    imem_req_valid = (state_q == StReq);
    imem_req_addr  = pc_q;
    inst_valid     = (state_q == StHold);
    inst           = inst_q;
    inst_pc        = inst_pc_q;
  end

endmodule

// File: tb/tb_ysyx_22040365_ifu.sv
// Self-checking bench for the fetch unit: directed boot/fetch/backpressure/redirect/reset
// scenarios followed by a randomized run, all checked against a transaction-level model
// (expected PC tracked from redirects and consumed instructions, memory as an address hash).
`timescale 1ns/1ps
module tb_ysyx_22040365_ifu;

  localparam logic [63:0] ResetPc = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  ysyx_22040365_ifu #(
    .ADDR_W  (64),
    .RESET_PC(ResetPc)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model / memory model state.
  logic [63:0] mpc;
  logic        mem_pending;
  logic [63:0] mem_addr;
  int unsigned mem_cnt;
  int unsigned mem_lat_max;
  logic        mem_hold;
  logic        mem_manual;
  int unsigned cycle;
  int unsigned idle_cnt;
  int unsigned n_deliv;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Memory contents: addi x(k), x(a[18:14]), k with k = word index + 1.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [11:0] k;
    k = a[13:2] + 12'd1;
    return {k, a[18:14], 3'b000, k[4:0], 7'h13};
  endfunction

  // One clock: advance the model on what was presented before the edge, check the
  // new outputs, then drive the memory response for the coming cycle.
  task automatic step();
    logic        p_rst, p_rv, p_rr, p_rsv, p_iv, p_ir, p_redir;
    logic [63:0] p_addr, p_rpc;
    p_rst   = rst;
    p_rv    = imem_req_valid;
    p_rr    = imem_req_ready;
    p_rsv   = imem_resp_valid;
    p_iv    = inst_valid;
    p_ir    = inst_ready;
    p_redir = redirect_valid;
    p_addr  = imem_req_addr;
    p_rpc   = redirect_pc;
    @(posedge clk);
    #1;
    cycle++;
    redirect_valid = 1'b0;
    if (p_rst && rst) begin
      if (p_redir) mpc = {p_rpc[63:2], 2'b00};
      else if (p_iv && p_ir) mpc = mpc + 64'd4;
      if (p_iv && p_ir && !p_redir) begin
        n_deliv++;
        idle_cnt = 0;
      end else begin
        idle_cnt++;
      end
      check_eq("req_inst_exclusive", {63'd0, imem_req_valid & inst_valid}, 64'd0);
      if (imem_req_valid) check_eq("req_addr", imem_req_addr, mpc);
      if (inst_valid) begin
        check_eq("inst_pc", inst_pc, mpc);
        check_eq("inst_data", {32'd0, inst}, {32'd0, mem_word(mpc)});
      end
      if (p_redir || (p_iv && p_ir)) check_eq("inst_valid_after", {63'd0, inst_valid}, 64'd0);
      else if (p_iv) check_eq("hold_valid", {63'd0, inst_valid}, 64'd1);
      if (p_rv && !p_rr && !p_redir) check_eq("stall_valid", {63'd0, imem_req_valid}, 64'd1);
      if (!mem_manual) begin
        if (p_rsv) mem_pending = 1'b0;
        if (p_rv && p_rr) begin
          check_eq("one_outstanding", {63'd0, mem_pending}, 64'd0);
          mem_pending = 1'b1;
          mem_addr    = p_addr;
          mem_cnt     = $urandom_range(mem_lat_max, 0);
        end
        if (mem_pending && !mem_hold && mem_cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_word(mem_addr);
        end else begin
          imem_resp_valid = 1'b0;
          imem_resp_data  = $urandom;
          if (mem_pending && mem_cnt > 0) mem_cnt--;
        end
      end
    end
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!imem_req_valid && n < 50) begin
      step();
      n++;
    end
    check_eq(tag, {63'd0, imem_req_valid}, 64'd1);
  endtask

  task automatic wait_inst(input string tag);
    int n;
    n = 0;
    while (!inst_valid && n < 50) begin
      step();
      n++;
    end
    check_eq(tag, {63'd0, inst_valid}, 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_valid"}, {63'd0, imem_req_valid}, 64'd0);
    check_eq({tag, "_req_addr"}, imem_req_addr, ResetPc);
    check_eq({tag, "_inst_valid"}, {63'd0, inst_valid}, 64'd0);
    check_eq({tag, "_inst"}, {32'd0, inst}, 64'h13);
    check_eq({tag, "_inst_pc"}, inst_pc, ResetPc);
  endtask

  logic [63:0] exp_pc   [3];
  logic [31:0] exp_data [3];
  int unsigned t_seen   [3];

  initial begin
    exp_pc   = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0008};
    exp_data = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
    rst             = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    inst_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 64'd0;
    mpc             = ResetPc;
    mem_pending     = 1'b0;
    mem_addr        = 64'd0;
    mem_cnt         = 0;
    mem_lat_max     = 0;
    mem_hold        = 1'b0;
    mem_manual      = 1'b0;
    cycle           = 0;
    idle_cnt        = 0;
    n_deliv         = 0;

    // Boot: three cycles in reset, first request one cycle after release.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    check_eq("boot_idle_no_req", {63'd0, imem_req_valid}, 64'd0);
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    step();
    check_eq("boot_req_valid", {63'd0, imem_req_valid}, 64'd1);
    check_eq("boot_req_addr", imem_req_addr, 64'h8000_0000);

    // Sequential fetch at full rate.
    for (int k = 0; k < 3; k++) begin
      wait_inst("seq_inst_timeout");
      t_seen[k] = cycle;
      check_eq("seq_pc", inst_pc, exp_pc[k]);
      check_eq("seq_data", {32'd0, inst}, {32'd0, exp_data[k]});
      if (k < 2) step();
    end
    check_eq("seq_rate_1", 64'(t_seen[1] - t_seen[0]), 64'd3);
    check_eq("seq_rate_2", 64'(t_seen[2] - t_seen[1]), 64'd3);

    // Backpressure on the third instruction.
    inst_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("bp_valid", {63'd0, inst_valid}, 64'd1);
      check_eq("bp_pc", inst_pc, 64'h8000_0008);
      check_eq("bp_no_req", {63'd0, imem_req_valid}, 64'd0);
    end
    inst_ready     = 1'b1;
    imem_req_ready = 1'b0;
    step();
    check_eq("bp_release_valid", {63'd0, inst_valid}, 64'd0);
    check_eq("bp_next_addr", imem_req_addr, 64'h8000_000C);

    // Stalled request: address held until accepted.
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("stall_req_valid", {63'd0, imem_req_valid}, 64'd1);
      check_eq("stall_req_addr", imem_req_addr, 64'h8000_000C);
    end
    imem_req_ready = 1'b1;

    // Redirect while waiting: stale response must be dropped.
    mem_hold = 1'b1;
    step();
    check_eq("rw_in_wait", {63'd0, imem_req_valid}, 64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1002;
    step();
    mem_hold = 1'b0;
    begin
      int n;
      n = 0;
      while (!imem_req_valid && n < 20) begin
        check_eq("rw_no_inst", {63'd0, inst_valid}, 64'd0);
        step();
        n++;
      end
    end
    check_eq("rw_req_valid", {63'd0, imem_req_valid}, 64'd1);
    check_eq("rw_req_addr", imem_req_addr, 64'h8000_1000);

    // Redirect in HOLD with inst_ready high in the same cycle.
    inst_ready = 1'b0;
    wait_inst("rh_inst_timeout");
    check_eq("rh_inst_pc", inst_pc, 64'h8000_1000);
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    step();
    check_eq("rh_inst_valid_drop", {63'd0, inst_valid}, 64'd0);
    wait_req("rh_req_timeout");
    check_eq("rh_req_addr", imem_req_addr, 64'h8000_0100);

    // Randomized run.
    mem_lat_max = 3;
    idle_cnt    = 0;
    n_deliv     = 0;
    for (int c = 0; c < 3000; c++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      inst_ready     = ($urandom_range(9, 0) < 7);
      if ($urandom_range(19, 0) == 0) begin
        redirect_valid = 1'b1;
        if ($urandom_range(3, 0) == 0)
          redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
        else
          redirect_pc = 64'h8000_0000 + 64'($urandom_range(8191, 0));
      end
      step();
      if (idle_cnt > 300) begin
        check_eq("watchdog_idle", 64'(idle_cnt), 64'd0);
        break;
      end
    end
    check_eq("random_progress", {63'd0, (n_deliv >= 100)}, 64'd1);

    // Async reset in the middle of WAIT; a late response must be ignored.
    mem_lat_max    = 0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    wait_req("rst_req_timeout");
    mem_hold = 1'b1;
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midwait_reset");
    mem_manual      = 1'b1;
    mem_pending     = 1'b0;
    mem_hold        = 1'b0;
    mpc             = ResetPc;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    step();
    check_reset_outputs("in_reset");
    rst = 1'b1;
    step();
    check_eq("late_resp_no_inst", {63'd0, inst_valid}, 64'd0);
    check_eq("reboot_req_valid", {63'd0, imem_req_valid}, 64'd1);
    check_eq("reboot_req_addr", imem_req_addr, ResetPc);
    imem_resp_valid = 1'b0;
    mem_manual      = 1'b0;
    wait_inst("reboot_inst_timeout");
    check_eq("reboot_inst_pc", inst_pc, ResetPc);
    check_eq("reboot_inst", {32'd0, inst}, 64'h0010_0093);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
